// File: rtl/mems_spi_if.sv
// Controller-side handshake (start/busy/word) and DAC pin bundle for mems_spi_master.
// The readback signals are only meaningful when MEMS_SPI_READBACK_EN is defined.
interface mems_spi_if #(
  parameter int unsigned DATA_WIDTH = 24
) ();
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  spi_cs_n;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport slave (
    input  start, data_in, spi_miso,
    output busy, spi_cs_n, spi_sclk, spi_mosi, rx_data, rx_valid
  );

  modport master (
    output start, data_in, spi_miso,
    input  busy, spi_cs_n, spi_sclk, spi_mosi, rx_data, rx_valid
  );
endinterface

// File: rtl/mems_spi_master.sv
// MSB-first SPI frame transmitter for the quad MEMS DAC (SYNC/SCLK/DIN), one word per start.
// Optional MISO readback capture is enabled by defining MEMS_SPI_READBACK_EN.
module mems_spi_master #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned LOAD_DELAY = 1
) (
  input  logic      clk,
  input  logic      rst,
  mems_spi_if.slave bus_if
);

  localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]  HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("mems_spi_master: DATA_WIDTH must be at least 2");
  end
  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $error("mems_spi_master: CLK_DIV must be in 1..255");
  end
  if (GAP_CYCLES > 255) begin : g_bad_gap
    $error("mems_spi_master: GAP_CYCLES must be in 0..255");
  end
  if (LOAD_DELAY > 1) begin : g_bad_load
    $error("mems_spi_master: LOAD_DELAY must be 0 or 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]            hcnt_q, hcnt_d;

  logic capture_c;
  logic half_done_c;
  logic rise_c;
  logic last_c;

  // Capture edge Ec: straight from IDLE when LOAD_DELAY is 0, else one cycle later from LOAD.
  assign capture_c   = (state_q == S_LOAD) ||
                       ((state_q == S_IDLE) && bus_if.start && (LOAD_DELAY == 0));
  assign half_done_c = (hcnt_q == HALF_LAST);
  assign rise_c      = (state_q == S_SHIFT) && half_done_c && !sclk_q;
  assign last_c      = rise_c && (bit_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_sh_d   = tx_sh_q;
    bit_cnt_d = bit_cnt_q;
    hcnt_d    = hcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          busy_d = 1'b1;
          if (LOAD_DELAY != 0) state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_SHIFT;
      S_SHIFT: begin
        if (half_done_c) begin
          hcnt_d = '0;
          sclk_d = ~sclk_q;
          if (last_c) begin
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end else if (rise_c) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            tx_sh_d   = tx_sh_q << 1;
            mosi_d    = tx_sh_q[DATA_WIDTH-2];
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (half_done_c) begin
          hcnt_d = '0;
          cs_n_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (hcnt_q == GAP_LAST) begin
          hcnt_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture_c) begin
      tx_sh_d   = bus_if.data_in;
      mosi_d    = bus_if.data_in[DATA_WIDTH-1];
      cs_n_d    = 1'b0;
      hcnt_d    = '0;
      bit_cnt_d = BIT_W'(DATA_WIDTH - 1);
      state_d   = S_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      tx_sh_q   <= '0;
      bit_cnt_q <= '0;
      hcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_sh_q   <= tx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign bus_if.busy     = busy_q;
  assign bus_if.spi_cs_n = cs_n_q;
  assign bus_if.spi_sclk = sclk_q;
  assign bus_if.spi_mosi = mosi_q;

`ifdef MEMS_SPI_READBACK_EN
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  // MISO is sampled on SCLK rising edges; the last sample completes the word at HOLD entry.
  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (capture_c) rx_sh_d = '0;
    if (rise_c) begin
      rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], bus_if.spi_miso};
      if (last_c) begin
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus_if.rx_data  = rx_data_q;
  assign bus_if.rx_valid = rx_valid_q;
`else
  logic unused_miso;
  assign unused_miso     = bus_if.spi_miso;
  assign bus_if.rx_data  = '0;
  assign bus_if.rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mems_spi_master.sv
// Scoreboard bench for mems_spi_master: a pin monitor decodes frames, tasks compare them
// against words pushed when each start is issued.
`timescale 1ns/1ps
module tb_mems_spi_master;

  localparam int unsigned DW  = 24;
  localparam int unsigned CD  = 4;
  localparam int unsigned GAP = 4;
  localparam int unsigned LD  = 1;
  localparam int BUSY_LEN = LD + (2 * DW + 1) * CD + GAP;
  localparam int CS_LOW   = (2 * DW + 1) * CD;
  localparam int RX_AT    = 2 * DW * CD + 1;

  typedef struct {
    logic [DW-1:0] word;
    int            bits;
    int            cs_low;
    int            gap;
  } frame_t;

  typedef struct {
    logic [DW-1:0] data;
    int            width;
    int            at_cs_low;
  } rx_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mems_spi_if #(.DATA_WIDTH(DW)) bus_if ();

  mems_spi_master #(
    .DATA_WIDTH(DW), .CLK_DIV(CD), .GAP_CYCLES(GAP), .LOAD_DELAY(LD)
  ) dut (
    .clk(clk), .rst(rst), .bus_if(bus_if)
  );

  frame_t        obs_q[$];
  logic [DW-1:0] exp_q[$];
  int            busy_q[$];
  rx_t           rx_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            mon_bits = 0;
  int            rx_total = 0;
  logic [DW-1:0] rb_word  = 24'hC0FFEE;

  // Pin monitor and DAC readback model, sampling on the falling clk edge.
  initial begin : monitor
    logic   prev_cs, prev_sclk, prev_busy, prev_rxv;
    frame_t cur;
    rx_t    rcur;
    int     busy_cnt, hi_cnt;
    prev_cs = 1'b1; prev_sclk = 1'b1; prev_busy = 1'b0; prev_rxv = 1'b0;
    busy_cnt = 0; hi_cnt = 0;
    cur  = '{word: '0, bits: 0, cs_low: 0, gap: 0};
    rcur = '{data: '0, width: 0, at_cs_low: 0};
    bus_if.spi_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur = '{word: '0, bits: 0, cs_low: 0, gap: 0};
        busy_cnt = 0; hi_cnt = 0; mon_bits = 0;
        bus_if.spi_miso = 1'b0;
      end else begin
        if (prev_cs && !bus_if.spi_cs_n) begin
          cur = '{word: '0, bits: 0, cs_low: 0, gap: hi_cnt};
          mon_bits = 0;
        end
        if (!bus_if.spi_cs_n) begin
          cur.cs_low++;
          hi_cnt = 0;
          if (prev_sclk && !bus_if.spi_sclk) begin
            cur.word = {cur.word[DW-2:0], bus_if.spi_mosi};
            cur.bits++;
            mon_bits = cur.bits;
            if (cur.bits <= DW) bus_if.spi_miso = rb_word[DW-cur.bits];
          end
        end else begin
          hi_cnt++;
        end
        if (!prev_cs && bus_if.spi_cs_n) obs_q.push_back(cur);
        if (bus_if.busy) busy_cnt++;
        else if (prev_busy) begin
          busy_q.push_back(busy_cnt);
          busy_cnt = 0;
        end
        if (bus_if.rx_valid) begin
          if (!prev_rxv) rcur = '{data: bus_if.rx_data, width: 0, at_cs_low: cur.cs_low};
          rcur.width++;
          rx_total++;
        end else if (prev_rxv) begin
          rx_q.push_back(rcur);
        end
      end
      prev_cs   = bus_if.spi_cs_n;
      prev_sclk = bus_if.spi_sclk;
      prev_busy = bus_if.busy;
      prev_rxv  = bus_if.rx_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] w);
    for (int i = 0; i < 1000 && bus_if.busy; i++) @(negedge clk);
    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    bus_if.data_in = w;
    exp_q.push_back(w);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 3000 && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_busy(input int n);
    for (int i = 0; i < 3000 && busy_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    bus_if.start = 1'b0;
    bus_if.data_in = '0;
    tick(3);
    n_checks++;
    if ({bus_if.busy, bus_if.spi_cs_n, bus_if.spi_sclk, bus_if.spi_mosi, bus_if.rx_valid} !== 5'b01100) begin
      n_fail++;
      $display("FAIL reset_pins: busy/cs_n/sclk/mosi/rx_valid got %b expected 01100",
               {bus_if.busy, bus_if.spi_cs_n, bus_if.spi_sclk, bus_if.spi_mosi, bus_if.rx_valid});
    end
    n_checks++;
    if (bus_if.rx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h expected 0", bus_if.rx_data);
    end
    @(negedge clk) rst = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if ({bus_if.busy, bus_if.spi_cs_n, bus_if.spi_sclk, bus_if.spi_mosi} !== 4'b0110) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_hold: %0d cycles off idle levels, expected 0", bad);
    end
  endtask

  task automatic test_single_frame();
    frame_t f;
    logic [DW-1:0] e;
    int b;
    send_frame(24'h3FA5C3);
    tick(5);
    bus_if.data_in = DW'($urandom);
    wait_obs(1);
    wait_busy(1);
    n_checks++;
    if (obs_q.size() != 1 || busy_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_done: frames %0d busy pulses %0d, expected 1 and 1", obs_q.size(), busy_q.size());
      return;
    end
    f = obs_q.pop_front();
    e = exp_q.pop_front();
    b = busy_q.pop_front();
    n_checks++;
    if (f.word !== e) begin n_fail++; $display("FAIL single_word: got %h expected %h", f.word, e); end
    n_checks++;
    if (f.bits != DW) begin n_fail++; $display("FAIL single_bits: got %0d expected %0d", f.bits, DW); end
    n_checks++;
    if (f.cs_low != CS_LOW) begin n_fail++; $display("FAIL single_cs_low: got %0d expected %0d", f.cs_low, CS_LOW); end
    n_checks++;
    if (b != BUSY_LEN) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", b, BUSY_LEN); end
  endtask

  task automatic test_collision();
    frame_t f;
    logic [DW-1:0] e;
    int b;
    send_frame(24'hA1B2C3);
    tick(49);
    bus_if.start = 1'b1;
    bus_if.data_in = 24'h111111;
    tick(1);
    bus_if.start = 1'b0;
    tick(150);
    bus_if.start = 1'b1;
    tick(1);
    n_checks++;
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL collide_busy_fall: busy got %b expected 0", bus_if.busy); end
    bus_if.data_in = 24'h5C3A96;
    exp_q.push_back(24'h5C3A96);
    tick(1);
    bus_if.start = 1'b0;
    n_checks++;
    if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL collide_restart: busy got %b expected 1", bus_if.busy); end
    wait_obs(2);
    wait_busy(2);
    repeat (300) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 2 || busy_q.size() != 2) begin
      n_fail++;
      $display("FAIL collide_count: frames %0d busy pulses %0d, expected 2 and 2", obs_q.size(), busy_q.size());
      obs_q.delete(); exp_q.delete(); busy_q.delete();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      b = busy_q.pop_front();
      n_checks++;
      if (f.word !== e || f.bits != DW) begin
        n_fail++;
        $display("FAIL collide_word%0d: got %h/%0d bits expected %h/%0d", k, f.word, f.bits, e, DW);
      end
      n_checks++;
      if (b != BUSY_LEN) begin n_fail++; $display("FAIL collide_busy%0d: got %0d expected %0d", k, b, BUSY_LEN); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[6];
    frame_t f;
    logic [DW-1:0] e;
    words[0] = 24'h280001;
    words[1] = 24'h300000;
    for (int k = 2; k < 6; k++) words[k] = {8'h18, 16'($urandom)};
    for (int k = 0; k < 6; k++) send_frame(words[k]);
    wait_obs(6);
    n_checks++;
    if (obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d frames expected 6", obs_q.size());
      obs_q.delete(); exp_q.delete();
      return;
    end
    for (int k = 0; k < 6; k++) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (f.word !== e || f.bits != DW) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got %h/%0d bits expected %h/%0d", k, f.word, f.bits, e, DW);
      end
      n_checks++;
      if (f.gap < int'(GAP)) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d expected >= %0d", k, f.gap, GAP); end
    end
    wait_busy(6);
    busy_q.delete();
  endtask

  task automatic test_async_reset();
    frame_t f;
    logic [DW-1:0] e;
    send_frame(24'hDEAD55);
    for (int i = 0; i < 2000 && mon_bits < 10; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.spi_cs_n, bus_if.spi_sclk, bus_if.busy, bus_if.spi_mosi} !== 4'b1100) begin
      n_fail++;
      $display("FAIL async_reset_pins: cs_n/sclk/busy/mosi got %b expected 1100",
               {bus_if.spi_cs_n, bus_if.spi_sclk, bus_if.busy, bus_if.spi_mosi});
    end
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy_q.size() != 0) begin
      n_fail++;
      $display("FAIL async_partial: frames %0d busy pulses %0d, expected 0 and 0", obs_q.size(), busy_q.size());
      obs_q.delete(); busy_q.delete();
    end
    send_frame(24'h0F1E2D);
    wait_obs(1);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL async_next_frame: got %0d frames expected 1", obs_q.size());
      return;
    end
    f = obs_q.pop_front();
    e = exp_q.pop_front();
    n_checks++;
    if (f.word !== e || f.bits != DW || f.cs_low != CS_LOW) begin
      n_fail++;
      $display("FAIL async_clean_frame: got %h/%0d bits/%0d low expected %h/%0d/%0d",
               f.word, f.bits, f.cs_low, e, DW, CS_LOW);
    end
    wait_busy(1);
    busy_q.delete();
  endtask

`ifdef MEMS_SPI_READBACK_EN
  task automatic test_readback();
    rx_t r;
    rx_q.delete();
    rb_word = 24'hC0FFEE;
    send_frame(24'h5A5A5A);
    wait_obs(1);
    obs_q.delete();
    exp_q.delete();
    repeat (10) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 1) begin
      n_fail++;
      $display("FAIL rb_count: got %0d rx pulses expected 1", rx_q.size());
      return;
    end
    r = rx_q.pop_front();
    n_checks++;
    if (r.data !== 24'hC0FFEE) begin n_fail++; $display("FAIL rb_data: got %h expected c0ffee", r.data); end
    n_checks++;
    if (r.width != 1) begin n_fail++; $display("FAIL rb_width: got %0d expected 1", r.width); end
    n_checks++;
    if (r.at_cs_low != RX_AT) begin n_fail++; $display("FAIL rb_timing: got %0d expected %0d", r.at_cs_low, RX_AT); end
  endtask
`else
  task automatic test_readback();
    n_checks++;
    if (rx_total != 0 || bus_if.rx_data !== '0) begin
      n_fail++;
      $display("FAIL rb_disabled: rx_valid cycles %0d rx_data %h expected 0 and 0", rx_total, bus_if.rx_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_collision();
    test_back_to_back();
    test_async_reset();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
